// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } arb_owner_t;

  localparam logic [3:0] MEM_BE_FULL = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; master = arbiter, slave = core/memory side.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ack;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  d_req;
  logic                  d_wr_en;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [3:0]            d_byte_en;
  logic                  d_ack;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  mem_req;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_byte_en;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;

  modport master (
    input  if_req, if_addr,
    output if_ack, if_rdata,
    input  d_req, d_wr_en, d_addr, d_wdata, d_byte_en,
    output d_ack, d_rdata,
    output mem_req, mem_wr_en, mem_addr, mem_wdata, mem_byte_en,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output busy
  );

  modport slave (
    output if_req, if_addr,
    input  if_ack, if_rdata,
    output d_req, d_wr_en, d_addr, d_wdata, d_byte_en,
    input  d_ack, d_rdata,
    input  mem_req, mem_wr_en, mem_addr, mem_wdata, mem_byte_en,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  busy
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Owner selection for the shared memory port.
// MEM_ARB_RR_EN: round-robin on conflict; otherwise data always beats fetch.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  arb_owner_t last_owner,
  output logic       grant_valid,
  output arb_owner_t grant_owner
);

  assign grant_valid = if_req | d_req;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant_owner = OWN_IF;
    if (if_req && d_req) begin
      // Conflict: hand the port to whoever was not served last
      if (last_owner == OWN_D) grant_owner = OWN_IF;
      else                     grant_owner = OWN_D;
    end else if (d_req) begin
      grant_owner = OWN_D;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = last_owner;

  // A data access belongs to an older instruction than the pending fetch
  always_comb begin
    grant_owner = OWN_IF;
    if (d_req) grant_owner = OWN_D;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one request/grant/valid memory port between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin conflict resolution (default: data over fetch).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.master bus
);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  arb_owner_t            r_owner;
  arb_owner_t            r_last_owner;
  arb_owner_t            w_grant_owner;
  logic                  w_grant_valid;
  logic                  w_mem_req;
  logic                  w_busy;
  logic                  w_ack;
  logic                  w_if_ack;
  logic                  w_d_ack;

  logic                  r_mem_wr_en;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [3:0]            r_mem_byte_en;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;

  mem_arb_pick u_pick (
    .if_req      (bus.if_req),
    .d_req       (bus.d_req),
    .last_owner  (r_last_owner),
    .grant_valid (w_grant_valid),
    .grant_owner (w_grant_owner)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_mem_req   = 1'b0;
    w_busy      = 1'b1;
    w_ack       = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        w_busy = 1'b0;
        if (w_grant_valid) w_state_nxt = ARB_REQ;
      end
      ARB_REQ: begin
        w_mem_req = 1'b1;
        if (bus.mem_gnt) w_state_nxt = ARB_RESP;
      end
      ARB_RESP: begin
        // Completion is acknowledged in the same cycle mem_rvalid arrives
        w_ack = bus.mem_rvalid;
        if (bus.mem_rvalid) w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  assign w_if_ack = w_ack && (r_owner == OWN_IF);
  assign w_d_ack  = w_ack && (r_owner == OWN_D);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ARB_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner       <= OWN_IF;
      r_last_owner  <= OWN_D;
      r_mem_wr_en   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_byte_en <= '0;
      r_if_rdata    <= '0;
      r_d_rdata     <= '0;
    end else begin
      if (r_state == ARB_IDLE && w_grant_valid) begin
        r_owner <= w_grant_owner;
        if (w_grant_owner == OWN_D) begin
          r_mem_wr_en   <= bus.d_wr_en;
          r_mem_addr    <= bus.d_addr;
          r_mem_wdata   <= bus.d_wdata;
          r_mem_byte_en <= bus.d_byte_en;
        end else begin
          r_mem_wr_en   <= 1'b0;
          r_mem_addr    <= bus.if_addr;
          r_mem_wdata   <= '0;
          r_mem_byte_en <= MEM_BE_FULL;
        end
      end
      if (w_ack)    r_last_owner <= r_owner;
      if (w_if_ack) r_if_rdata   <= bus.mem_rdata;
      if (w_d_ack)  r_d_rdata    <= bus.mem_rdata;
    end
  end

  assign bus.mem_req     = w_mem_req;
  assign bus.mem_wr_en   = r_mem_wr_en;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.mem_byte_en = r_mem_byte_en;
  assign bus.busy        = w_busy;
  assign bus.if_ack      = w_if_ack;
  assign bus.d_ack       = w_d_ack;
  assign bus.if_rdata    = w_if_ack ? bus.mem_rdata : r_if_rdata;
  assign bus.d_rdata     = w_d_ack  ? bus.mem_rdata : r_d_rdata;

endmodule
